// File: rtl/ProcessorDefs.sv
// ---------------------------------------------------------------------------
// ProcessorDefs
//   Shared processor type definitions.
//   arb_state_t : ownership state of the instruction/data memory port arbiter
//   grant_t     : which requester was granted last; also consumed by
//                 debug/trace logic, so its encoding is part of the interface
// ---------------------------------------------------------------------------
package ProcessorDefs;

  typedef enum logic [1:0] {
    IDLE,
    OWN_I,
    OWN_D
  } arb_state_t;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } grant_t;

endpackage : ProcessorDefs

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between the instruction fetch path and
//   the data load/store path. Conflicts are resolved round-robin, or always
//   in favour of data when DATA_PRIORITY = 1. Once a request has been sent
//   to a stalling memory it keeps the port until the memory completes it.
//
// Ports
//   i_clock, i_reset        clock; synchronous active-low reset
//   i_inst_*, o_inst_*      fetch request in, fetched word / busy out
//   i_data_*, o_data_*      load/store request in, load data / busy out
//   o_mem_*                 shared memory request (combinational from inputs)
//   i_mem_rdata, i_mem_busy memory read data and stall
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import ProcessorDefs::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  // instruction fetch port
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  input  logic                    i_inst_re,
  output logic [DATA_WIDTH-1:0]   o_inst_inst,
  output logic                    o_inst_busy,
  // data load/store port
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic                    i_data_re,
  input  logic                    i_data_we,
  input  logic [DATA_WIDTH/8-1:0] i_data_be,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_data_busy,
  // shared memory
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_re,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_busy
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t r_state;
  arb_state_t w_next_state;
  grant_t     r_last_grant;
  grant_t     w_next_last_grant;

  logic w_inst_req;
  logic w_data_req;
  logic w_fwd_inst;
  logic w_fwd_data;

  assign w_inst_req = i_inst_re;
  assign w_data_req = i_data_re | i_data_we;

  // Read data goes to both ports unconditionally; busy tells each port
  // whether the word is meant for it.
  assign o_inst_inst  = i_mem_rdata;
  assign o_data_rdata = i_mem_rdata;

  // -------------------------------------------------------------------------
  // Winner selection and next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default on the first lines of the
  // block, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_fwd_inst        = 1'b0;
    w_fwd_data        = 1'b0;
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;

    unique case (r_state)
      IDLE: begin
        if (w_inst_req && w_data_req) begin
          // Conflict: data wins if configured so, otherwise whoever was
          // not served last.
          if (DATA_PRIORITY || (r_last_grant == GRANT_INST)) w_fwd_data = 1'b1;
          else                                               w_fwd_inst = 1'b1;
        end else begin
          w_fwd_inst = w_inst_req;
          w_fwd_data = w_data_req;
        end

        if (w_fwd_inst) begin
          if (i_mem_busy) w_next_state      = OWN_I;
          else            w_next_last_grant = GRANT_INST;
        end else if (w_fwd_data) begin
          if (i_mem_busy) w_next_state      = OWN_D;
          else            w_next_last_grant = GRANT_DATA;
        end
      end

      OWN_I: begin
        // Locked to the fetch; a dropped request releases the port without
        // counting as a grant.
        w_fwd_inst = w_inst_req;
        if (w_inst_req && i_mem_busy) begin
          w_next_state = OWN_I;
        end else begin
          w_next_state = IDLE;
          if (w_inst_req) w_next_last_grant = GRANT_INST;
        end
      end

      OWN_D: begin
        w_fwd_data = w_data_req;
        if (w_data_req && i_mem_busy) begin
          w_next_state = OWN_D;
        end else begin
          w_next_state = IDLE;
          if (w_data_req) w_next_last_grant = GRANT_DATA;
        end
      end

      default: w_next_state = IDLE;
    endcase

    // Reset silences the memory port regardless of state.
    if (!i_reset) begin
      w_fwd_inst = 1'b0;
      w_fwd_data = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Memory request mux
  // -------------------------------------------------------------------------
  always_comb begin
    o_mem_addr  = '0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    if (w_fwd_inst) begin
      o_mem_addr = i_inst_addr;
      o_mem_re   = 1'b1;
      o_mem_be   = {BE_WIDTH{1'b1}};
    end else if (w_fwd_data) begin
      o_mem_addr  = i_data_addr;
      o_mem_re    = i_data_re;
      o_mem_we    = i_data_we;
      o_mem_be    = i_data_be;
      o_mem_wdata = i_data_wdata;
    end
  end

  // A requester is released only in the cycle its own forwarded request
  // completes; during reset both ports report busy.
  assign o_inst_busy = ~i_reset | (w_inst_req & ~(w_fwd_inst & ~i_mem_busy));
  assign o_data_busy = ~i_reset | (w_data_req & ~(w_fwd_data & ~i_mem_busy));

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order or of other always_ff blocks.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_DATA;   // first conflict after reset goes to fetch
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Drives a round-robin instance and a data-priority instance from the same
//   stimulus and compares every output of both against a transaction-level
//   reference model each cycle, plus explicit expectations for directed steps.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] inst_addr;
  logic          inst_re;
  logic [AW-1:0] data_addr;
  logic          data_re;
  logic          data_we;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;

  // round-robin instance outputs
  logic [DW-1:0] rr_inst_inst, rr_data_rdata, rr_mem_wdata;
  logic          rr_inst_busy, rr_data_busy, rr_mem_re, rr_mem_we;
  logic [AW-1:0] rr_mem_addr;
  logic [BW-1:0] rr_mem_be;
  // data-priority instance outputs
  logic [DW-1:0] dp_inst_inst, dp_data_rdata, dp_mem_wdata;
  logic          dp_inst_busy, dp_data_busy, dp_mem_re, dp_mem_we;
  logic [AW-1:0] dp_mem_addr;
  logic [BW-1:0] dp_mem_be;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1'b0)) u_dut_rr (
    .i_clock(clk), .i_reset(rst_n),
    .i_inst_addr(inst_addr), .i_inst_re(inst_re),
    .o_inst_inst(rr_inst_inst), .o_inst_busy(rr_inst_busy),
    .i_data_addr(data_addr), .i_data_re(data_re), .i_data_we(data_we),
    .i_data_be(data_be), .i_data_wdata(data_wdata),
    .o_data_rdata(rr_data_rdata), .o_data_busy(rr_data_busy),
    .o_mem_addr(rr_mem_addr), .o_mem_re(rr_mem_re), .o_mem_we(rr_mem_we),
    .o_mem_be(rr_mem_be), .o_mem_wdata(rr_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_busy(mem_busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_PRIORITY(1'b1)) u_dut_dp (
    .i_clock(clk), .i_reset(rst_n),
    .i_inst_addr(inst_addr), .i_inst_re(inst_re),
    .o_inst_inst(dp_inst_inst), .o_inst_busy(dp_inst_busy),
    .i_data_addr(data_addr), .i_data_re(data_re), .i_data_we(data_we),
    .i_data_be(data_be), .i_data_wdata(data_wdata),
    .o_data_rdata(dp_data_rdata), .o_data_busy(dp_data_busy),
    .o_mem_addr(dp_mem_addr), .o_mem_re(dp_mem_re), .o_mem_we(dp_mem_we),
    .o_mem_be(dp_mem_be), .o_mem_wdata(dp_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_busy(mem_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model, index 0 = round-robin, 1 = data priority.
  // holder: 0 = port free, 1 = fetch holds it, 2 = data holds it.
  // served_data: the last completed transaction was a data one.
  int holder[2]      = '{0, 0};
  bit served_data[2] = '{1'b1, 1'b1};
  int fwd_now[2]     = '{0, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Who the memory should be serving this cycle (0 none, 1 fetch, 2 data).
  function automatic int who_is_served(input int p);
    bit want_i = inst_re;
    bit want_d = data_re | data_we;
    if (!rst_n)           return 0;
    if (holder[p] == 1)   return want_i ? 1 : 0;
    if (holder[p] == 2)   return want_d ? 2 : 0;
    if (want_i && want_d) return (p == 1 || !served_data[p]) ? 2 : 1;
    if (want_i)           return 1;
    if (want_d)           return 2;
    return 0;
  endfunction

  task automatic check_port(input int p, input string nm,
                            input logic [AW-1:0] addr, input logic re, input logic we,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd,
                            input logic ib, input logic db,
                            input logic [DW-1:0] ii, input logic [DW-1:0] dr);
    int  f    = fwd_now[p];
    bit  done = (f != 0) && !mem_busy;
    logic [AW-1:0] e_addr = (f == 1) ? inst_addr : (f == 2) ? data_addr : '0;
    logic          e_re   = (f == 1) ? 1'b1 : (f == 2) ? data_re : 1'b0;
    logic          e_we   = (f == 2) ? data_we : 1'b0;
    logic [BW-1:0] e_be   = (f == 1) ? {BW{1'b1}} : (f == 2) ? data_be : '0;
    logic [DW-1:0] e_wd   = (f == 2) ? data_wdata : '0;
    logic          e_ib   = !rst_n ? 1'b1 : (inst_re && !(f == 1 && done));
    logic          e_db   = !rst_n ? 1'b1 : ((data_re || data_we) && !(f == 2 && done));
    check({nm, "_mem_addr"},   64'(addr), 64'(e_addr));
    check({nm, "_mem_re"},     64'(re),   64'(e_re));
    check({nm, "_mem_we"},     64'(we),   64'(e_we));
    check({nm, "_mem_be"},     64'(be),   64'(e_be));
    check({nm, "_mem_wdata"},  64'(wd),   64'(e_wd));
    check({nm, "_inst_busy"},  64'(ib),   64'(e_ib));
    check({nm, "_data_busy"},  64'(db),   64'(e_db));
    check({nm, "_inst_inst"},  64'(ii),   64'(mem_rdata));
    check({nm, "_data_rdata"}, 64'(dr),   64'(mem_rdata));
  endtask

  // Compare both instances against the model mid-cycle.
  task automatic sample();
    @(negedge clk);
    for (int p = 0; p < 2; p++) fwd_now[p] = who_is_served(p);
    check_port(0, "rr", rr_mem_addr, rr_mem_re, rr_mem_we, rr_mem_be, rr_mem_wdata,
               rr_inst_busy, rr_data_busy, rr_inst_inst, rr_data_rdata);
    check_port(1, "dp", dp_mem_addr, dp_mem_re, dp_mem_we, dp_mem_be, dp_mem_wdata,
               dp_inst_busy, dp_data_busy, dp_inst_inst, dp_data_rdata);
  endtask

  // Advance the model across the clock edge; inputs change 1 ns later.
  task automatic advance();
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        holder[p]      = 0;
        served_data[p] = 1'b1;
      end else if (fwd_now[p] != 0 && !mem_busy) begin
        served_data[p] = (fwd_now[p] == 2);
        holder[p]      = 0;
      end else begin
        holder[p] = fwd_now[p];   // stalled: keep it; nothing sent: port free
      end
    end
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    inst_addr  = 32'h0000_0040;
    inst_re    = 1'b1;
    data_addr  = 32'h0000_2000;
    data_re    = 1'b1;
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_wdata = 32'h0;
    mem_rdata  = 32'hA5A5_0001;
    mem_busy   = 1'b0;

    // Reset held with both requesting: silent port, both busy.
    repeat (3) begin
      sample();
      check("rst_mem_re",    64'(rr_mem_re),    64'd0);
      check("rst_mem_we",    64'(rr_mem_we),    64'd0);
      check("rst_inst_busy", 64'(rr_inst_busy), 64'd1);
      check("rst_data_busy", 64'(rr_data_busy), 64'd1);
      advance();
    end

    // Continuous conflict, zero-wait: I, D, I, D ... on round-robin,
    // always D on the data-priority instance.
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("alt_addr", 64'(rr_mem_addr), (k % 2 == 0) ? 64'h40 : 64'h2000);
      check("alt_loser_busy", (k % 2 == 0) ? 64'(rr_data_busy) : 64'(rr_inst_busy), 64'd1);
      check("prio_addr",      64'(dp_mem_addr),  64'h2000);
      check("prio_inst_busy", 64'(dp_inst_busy), 64'd1);
      advance();
    end

    // Uncontested zero-wait fetch.
    data_re   = 1'b0;
    inst_addr = 32'h0000_0100;
    mem_rdata = 32'h1234_5678;
    sample();
    check("fetch_addr", 64'(rr_mem_addr),  64'h100);
    check("fetch_re",   64'(rr_mem_re),    64'd1);
    check("fetch_busy", 64'(rr_inst_busy), 64'd0);
    check("fetch_word", 64'(rr_inst_inst), 64'h1234_5678);
    advance();

    // Store wins the conflict and stalls 3 cycles; fetch follows in cycle 5.
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      mem_busy = (c <= 3);
      sample();
      if (c <= 4) begin
        check("st_addr",  64'(rr_mem_addr),  64'h2000);
        check("st_we",    64'(rr_mem_we),    64'd1);
        check("st_be",    64'(rr_mem_be),    64'h3);
        check("st_wdata", 64'(rr_mem_wdata), 64'hDEAD_BEEF);
        check("st_ibusy", 64'(rr_inst_busy), 64'd1);
      end else begin
        check("st_next_fetch", 64'(rr_mem_addr), 64'h100);
        check("st_next_re",    64'(rr_mem_re),   64'd1);
      end
      advance();
    end

    // Reset in the middle of a stalled store, then an immediate fetch.
    inst_re  = 1'b0;
    mem_busy = 1'b1;
    sample();
    advance();
    rst_n = 1'b0;
    sample();
    check("abort_we", 64'(rr_mem_we), 64'd0);
    check("abort_re", 64'(rr_mem_re), 64'd0);
    advance();
    rst_n     = 1'b1;
    data_we   = 1'b0;
    inst_re   = 1'b1;
    inst_addr = 32'h0000_0300;
    mem_busy  = 1'b0;
    sample();
    check("post_abort_addr", 64'(rr_mem_addr),  64'h300);
    check("post_abort_busy", 64'(rr_inst_busy), 64'd0);
    advance();

    // Random traffic with sticky requests, stalls, drops and resets.
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) inst_re = ~inst_re;
      if ($urandom_range(0, 3) == 0) {data_re, data_we} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) inst_addr = $urandom();
      if ($urandom_range(0, 2) == 0) data_addr = $urandom();
      data_be    = 4'($urandom_range(0, 15));
      data_wdata = $urandom();
      mem_rdata  = $urandom();
      mem_busy   = ($urandom_range(0, 2) == 0);
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
